// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_IDX_W     = 5;
   localparam int unsigned CNT_W_DEFAULT = 32;
   localparam int unsigned WAIT_CNT_W    = 8;
   localparam logic [31:0] NOP_INST      = 32'h0000_0013;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Side-band inputs from ID/EX/MEM and per-stage control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if;
   import hazard_pkg::*;

   reg_idx_t IF_ID_Rs1;
   reg_idx_t IF_ID_Rs2;
   logic     IF_ID_UseRs1;
   logic     IF_ID_UseRs2;
   logic     ID_EX_MemRead;
   reg_idx_t ID_EX_Rd;
   logic     EX_Redirect;
   logic     dmem_req;
   logic     dmem_ready;

   logic     PCWrite;
   logic     PCSel_Redirect;
   logic     IF_ID_Stall;
   logic     IF_ID_Flush;
   logic     Control_Sig_Stall;
   logic     ID_EX_Flush;
   logic     Pipe_Freeze;
   logic     mem_timeout_err;

   // Controller side.
   modport master (
      input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2,
      input  ID_EX_MemRead, ID_EX_Rd, EX_Redirect, dmem_req, dmem_ready,
      output PCWrite, PCSel_Redirect, IF_ID_Stall, IF_ID_Flush,
      output Control_Sig_Stall, ID_EX_Flush, Pipe_Freeze, mem_timeout_err
   );

   // Pipeline side.
   modport slave (
      output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2,
      output ID_EX_MemRead, ID_EX_Rd, EX_Redirect, dmem_req, dmem_ready,
      input  PCWrite, PCSel_Redirect, IF_ID_Stall, IF_ID_Flush,
      input  Control_Sig_Stall, ID_EX_Flush, Pipe_Freeze, mem_timeout_err
   );

endinterface

// File: rtl/lu_hazard_detect.sv
// Load-use comparator: the load in EX writes a register the decode instruction reads.
module lu_hazard_detect
   import hazard_pkg::*;
(
   input  reg_idx_t rs1,
   input  reg_idx_t rs2,
   input  logic     use_rs1,
   input  logic     use_rs2,
   input  logic     ex_mem_read,
   input  reg_idx_t ex_rd,
   output logic     lu_hazard
);

   // x0 is never a real dependency.
   always_comb begin
      lu_hazard = ex_mem_read && (ex_rd != '0) &&
                  ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipeline_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]       stall_cycles,
   output logic [CNT_W-1:0]       flush_count,
   output logic [CNT_W-1:0]       freeze_cycles
`endif
);

   localparam logic [WAIT_CNT_W-1:0] TimeoutVal = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_CNT_W-1:0] WaitMax    = '1;

   hz_state_e             state_q, state_d;
   logic                  pend_q, pend_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  lu_hazard;
   logic                  mem_stall;
   logic                  redirect;

   lu_hazard_detect u_lu_hazard_detect (
      .rs1         (hz.IF_ID_Rs1),
      .rs2         (hz.IF_ID_Rs2),
      .use_rs1     (hz.IF_ID_UseRs1),
      .use_rs2     (hz.IF_ID_UseRs2),
      .ex_mem_read (hz.ID_EX_MemRead),
      .ex_rd       (hz.ID_EX_Rd),
      .lu_hazard   (lu_hazard)
   );

   assign mem_stall = hz.dmem_req & ~hz.dmem_ready;
   // A redirect deferred by a memory freeze fires as soon as the pipeline runs again.
   assign redirect  = hz.EX_Redirect | pend_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (mem_stall)     state_d = MEM_WAIT;
         MEM_WAIT: if (hz.dmem_ready) state_d = RUN;
         default:                     state_d = RUN;
      endcase
   end

   // Next values of the pending redirect, wait counter and sticky timeout flag.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               pend_d = pend_q | hz.EX_Redirect;
               cnt_d  = WAIT_CNT_W'(1);
            end else if (redirect) begin
               pend_d = 1'b0;
            end
         end
         MEM_WAIT: begin
            // Redirect arriving on the ready cycle is still captured.
            pend_d = pend_q | hz.EX_Redirect;
            if (hz.dmem_ready)        cnt_d = '0;
            else if (cnt_q != WaitMax) cnt_d = cnt_q + WAIT_CNT_W'(1);
         end
         default: ;
      endcase
      if ((state_d == MEM_WAIT) && (cnt_d == TimeoutVal)) err_d = 1'b1;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 1'b0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   // Mealy outputs, priority freeze > redirect > load-use.
   always_comb begin
      hz.PCWrite           = 1'b1;
      hz.PCSel_Redirect    = 1'b0;
      hz.IF_ID_Stall       = 1'b0;
      hz.IF_ID_Flush       = 1'b0;
      hz.Control_Sig_Stall = 1'b0;
      hz.ID_EX_Flush       = 1'b0;
      hz.Pipe_Freeze       = 1'b0;
      hz.mem_timeout_err   = err_q;
      if (!rst_n || (state_q == MEM_WAIT) || mem_stall) begin
         hz.PCWrite     = 1'b0;
         hz.IF_ID_Stall = 1'b1;
         hz.Pipe_Freeze = 1'b1;
      end else if (redirect) begin
         hz.PCSel_Redirect = 1'b1;
         hz.IF_ID_Flush    = 1'b1;
         hz.ID_EX_Flush    = 1'b1;
      end else if (lu_hazard) begin
         hz.PCWrite           = 1'b0;
         hz.IF_ID_Stall       = 1'b1;
         hz.Control_Sig_Stall = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Performance counters, wrapping on overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles  <= '0;
         flush_count   <= '0;
         freeze_cycles <= '0;
      end else begin
         if (hz.Control_Sig_Stall) stall_cycles  <= stall_cycles + CNT_W'(1);
         if (hz.PCSel_Redirect)    flush_count   <= flush_count + CNT_W'(1);
         if (hz.Pipe_Freeze)       freeze_cycles <= freeze_cycles + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam int unsigned Timeout = 4;

   // Output vector order: {PCWrite, PCSel, IF_ID_Stall, IF_ID_Flush, CtrlStall, ID_EX_Flush,
   // Pipe_Freeze, err}
   localparam logic [7:0] ORun = 8'b1000_0000;
   localparam logic [7:0] OLu  = 8'b0010_1000;
   localparam logic [7:0] ORed = 8'b1101_0100;
   localparam logic [7:0] OFrz = 8'b0010_0010;
   localparam logic [7:0] ORst = 8'b0010_0010;
   localparam logic [7:0] OErr = 8'b0000_0001;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count, freeze_cycles;
`endif

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT (Timeout)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles  (stall_cycles),
      .flush_count   (flush_count),
      .freeze_cycles (freeze_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dut_out();
      return {hz.PCWrite, hz.PCSel_Redirect, hz.IF_ID_Stall, hz.IF_ID_Flush,
              hz.Control_Sig_Stall, hz.ID_EX_Flush, hz.Pipe_Freeze, hz.mem_timeout_err};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: in a memory wait, redirect owed, MEM_WAIT cycle index, sticky error.
   logic m_wait, m_pend, m_err;
   int   m_n;

   function automatic logic [7:0] model_out();
      logic lu;
      lu = hz.ID_EX_MemRead && (hz.ID_EX_Rd != 5'd0) &&
           ((hz.IF_ID_UseRs1 && hz.ID_EX_Rd == hz.IF_ID_Rs1) ||
            (hz.IF_ID_UseRs2 && hz.ID_EX_Rd == hz.IF_ID_Rs2));
      if (!rst_n) return ORst;
      if (m_wait || (hz.dmem_req && !hz.dmem_ready)) return OFrz | {7'd0, m_err};
      if (hz.EX_Redirect || m_pend) return ORed | {7'd0, m_err};
      if (lu) return OLu | {7'd0, m_err};
      return ORun | {7'd0, m_err};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait <= 1'b0;
         m_pend <= 1'b0;
         m_err  <= 1'b0;
         m_n    <= 0;
      end else if (m_wait) begin
         m_pend <= m_pend | hz.EX_Redirect;
         if (hz.dmem_ready) begin
            m_wait <= 1'b0;
            m_n    <= 0;
         end else begin
            m_n <= m_n + 1;
            if (m_n + 1 >= int'(Timeout)) m_err <= 1'b1;
         end
      end else if (hz.dmem_req && !hz.dmem_ready) begin
         m_wait <= 1'b1;
         m_pend <= m_pend | hz.EX_Redirect;
         m_n    <= 1;
         if (Timeout <= 1) m_err <= 1'b1;
      end else if (hz.EX_Redirect || m_pend) begin
         m_pend <= 1'b0;
      end
   end

   // Every cycle: outputs against the model, sampled mid-cycle.
   always @(negedge clk) chk("cycle", dut_out(), model_out());

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [7:0] exp);
      #2;
      chk(name, dut_out(), exp);
   endtask

   task automatic idle();
      hz.IF_ID_Rs1 = '0; hz.IF_ID_Rs2 = '0; hz.IF_ID_UseRs1 = 1'b0; hz.IF_ID_UseRs2 = 1'b0;
      hz.ID_EX_MemRead = 1'b0; hz.ID_EX_Rd = '0; hz.EX_Redirect = 1'b0;
      hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
   endtask

   task automatic set_lu(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic u1, input logic [4:0] r2, input logic u2);
      hz.ID_EX_MemRead = mr; hz.ID_EX_Rd = rd;
      hz.IF_ID_Rs1 = r1; hz.IF_ID_UseRs1 = u1; hz.IF_ID_Rs2 = r2; hz.IF_ID_UseRs2 = u2;
   endtask

   initial begin
      idle();
      lit("reset_state", ORst);
      #10 rst_n = 1'b1;
      tick();
      lit("idle_run", ORun);

      // Load-use on rs1 stalls one cycle, then the load moves on.
      tick(); set_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); lit("lu_rs1", OLu);
      tick(); idle(); lit("lu_release", ORun);
      tick(); set_lu(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0); lit("lu_x0", ORun);
      tick(); set_lu(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0); lit("lu_rs2_unused", ORun);
      tick(); set_lu(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1); lit("lu_rs2", OLu);
      tick(); idle();

      // Redirect wins over load-use.
      tick(); set_lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); hz.EX_Redirect = 1'b1;
      lit("redirect_over_lu", ORed);
      tick(); idle(); lit("after_redirect", ORun);

      // Three not-ready cycles then ready: four frozen, redirect owed afterwards.
      tick(); hz.dmem_req = 1'b1; lit("mw_c1", OFrz);
      tick(); hz.EX_Redirect = 1'b1; lit("mw_c2", OFrz);
      tick(); hz.EX_Redirect = 1'b0; lit("mw_c3", OFrz);
      tick(); hz.dmem_ready = 1'b1; lit("mw_c4_ready", OFrz);
      tick(); idle(); lit("mw_pending_redirect", ORed);
      tick(); lit("mw_back_to_run", ORun);

      // Redirect in the stall-entry cycle is deferred.
      tick(); hz.dmem_req = 1'b1; hz.EX_Redirect = 1'b1; lit("stall_and_redirect", OFrz);
      tick(); hz.EX_Redirect = 1'b0; hz.dmem_ready = 1'b1; lit("stall_ready", OFrz);
      tick(); idle(); lit("deferred_redirect", ORed);

      // Redirect coinciding with ready is not lost.
      tick(); hz.dmem_req = 1'b1; lit("mw2_c1", OFrz);
      tick(); hz.dmem_ready = 1'b1; hz.EX_Redirect = 1'b1; lit("ready_with_redirect", OFrz);
      tick(); idle(); lit("latched_redirect", ORed);
      tick(); lit("run_again", ORun);

      // Timeout after four MEM_WAIT cycles; flag sticks after ready.
      tick(); hz.dmem_req = 1'b1; lit("to_c1", OFrz);
      tick(); lit("to_mw1", OFrz);
      tick(); lit("to_mw2", OFrz);
      tick(); lit("to_mw3", OFrz);
      tick(); lit("to_mw4_err", OFrz | OErr);
      tick(); lit("to_mw5", OFrz | OErr);
      tick(); hz.dmem_ready = 1'b1; lit("to_ready", OFrz | OErr);
      tick(); idle(); lit("to_sticky", ORun | OErr);
      tick(); lit("to_sticky2", ORun | OErr);

      // Reset during a wait with a redirect captured.
      tick(); hz.dmem_req = 1'b1; lit("rw_c1", OFrz | OErr);
      tick(); hz.EX_Redirect = 1'b1; lit("rw_mw1", OFrz | OErr);
      tick(); hz.EX_Redirect = 1'b0;
      #1 rst_n = 1'b0;
      lit("reset_mid_wait", ORst);
      #4 rst_n = 1'b1; idle();
      tick(); lit("after_reset_run", ORun);
      tick(); lit("after_reset_run2", ORun);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards, applies taken-branch/jump redirects from EX, and freezes the whole pipeline while data memory is not ready.
- Drives the per-stage control inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable.
- Sits beside the decode stage; consumes ID/EX and EX/MEM side-band signals.

Parameters:
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout_err is raised (range 1..255).
CNT_W, 32, width of performance counters (optional feature only).

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
IF_ID_Rs1  in  5  rs1 of instruction in decode
IF_ID_Rs2  in  5  rs2 of instruction in decode
IF_ID_UseRs1  in  1  decode instruction reads rs1
IF_ID_UseRs2  in  1  decode instruction reads rs2
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_Rd  in  5  destination of instruction in EX
EX_Redirect  in  1  taken branch or jump resolved in EX this cycle
dmem_req  in  1  EX_MEM_MemRead | EX_MEM_MemWrite
dmem_ready  in  1  data memory completes access this cycle
PCWrite  out  1  PC register update enable
PCSel_Redirect  out  1  PC loads EX target instead of PC+4
IF_ID_Stall  out  1  hold IF/ID
IF_ID_Flush  out  1  load NOP (32'h00000013) into IF/ID
Control_Sig_Stall  out  1  inject bubble into ID/EX
ID_EX_Flush  out  1  clear ID/EX
Pipe_Freeze  out  1  hold ID/EX, EX/MEM, MEM/WB contents
mem_timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n=0, async): state=RUN, pend_redirect=0, wait_cnt=0, mem_timeout_err=0.
  - While rst_n=0, outputs are forced: PCWrite=0, IF_ID_Stall=1, Pipe_Freeze=1, all others 0.
- All outputs are combinational (Mealy) from state, registers and inputs: zero-cycle latency to the pipeline registers.
- States: RUN, MEM_WAIT.
- lu_hazard = ID_EX_MemRead & (ID_EX_Rd!=0) & ((UseRs1 & Rd==Rs1) | (UseRs2 & Rd==Rs2)).
- mem_stall = dmem_req & ~dmem_ready.
- Priority: mem_stall > redirect > lu_hazard.
- RUN:
  - mem_stall:
    - Outputs: Pipe_Freeze=1, IF_ID_Stall=1, PCWrite=0.
    - If EX_Redirect, set pend_redirect.
    - Next state MEM_WAIT, wait_cnt=1.
  - redirect (EX_Redirect | pend_redirect):
    - Outputs: PCWrite=1, PCSel_Redirect=1, IF_ID_Flush=1, ID_EX_Flush=1.
    - Clear pend_redirect.
    - lu_hazard is ignored (the decode instruction is flushed).
  - lu_hazard: PCWrite=0, IF_ID_Stall=1, Control_Sig_Stall=1 for exactly one cycle. The load then advances, so the hazard self-clears.
  - else: PCWrite=1, all stall/flush outputs 0.
- MEM_WAIT:
  - Outputs: Pipe_Freeze=1, IF_ID_Stall=1, PCWrite=0; EX_Redirect is captured into pend_redirect.
  - wait_cnt increments, saturating at 255.
  - When wait_cnt reaches MEM_TIMEOUT, set mem_timeout_err (sticky until reset); waiting continues.
  - dmem_ready=1: this cycle still frozen; next state RUN, wait_cnt=0.
  - A pending redirect is applied on the first RUN cycle.
- Simultaneous dmem_ready and EX_Redirect in MEM_WAIT: the redirect is latched, not lost.
- Reset mid-MEM_WAIT drops the pending redirect and the access.

Optional Feature:
HAZARD_PERF_CNT_EN: adds outputs stall_cycles[CNT_W], flush_count[CNT_W], freeze_cycles[CNT_W]; all reset to 0 and wrap on overflow.
- stall_cycles increments on each load-use stall cycle.
- flush_count increments on each redirect cycle.
- freeze_cycles increments on each Pipe_Freeze cycle while rst_n=1.
Without the macro, the ports and counters are absent and there is no other change.

Decomposition:
Shared package (hazard_pkg):
- State enum (RUN, MEM_WAIT).
- NOP_INST=32'h00000013.
- Reg-index width 5.
- Counter width default.
Sub-module lu_hazard_detect: purely combinational comparator producing lu_hazard. Everything else lives in the top module.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs1=5, UseRs1=1 -> one cycle of PCWrite=0, IF_ID_Stall=1, Control_Sig_Stall=1; next cycle PCWrite=1.
- x0 destination: same as above with ID_EX_Rd=0 -> no stall. With UseRs2=0, Rs2 match only -> no stall.
- Redirect: EX_Redirect=1 with lu_hazard also true -> IF_ID_Flush=1, ID_EX_Flush=1, PCSel_Redirect=1, PCWrite=1, Control_Sig_Stall=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> Pipe_Freeze=1 for 4 cycles, then RUN. An EX_Redirect pulse during the wait produces a redirect in the first RUN cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles -> mem_timeout_err rises on the 4th wait cycle and stays 1 after ready, until rst_n pulse.
- Async reset asserted mid-MEM_WAIT -> immediately PCWrite=0, Pipe_Freeze=1, err=0; after release, state RUN with no pending redirect.
